// File: rtl/fpu_ss_wb_arbiter_if.sv
// Writeback bus between the FPU subsystem result producers and the regfile/core.
// The arbiter takes the slave view; producers and the core together form the master view.
interface fpu_ss_wb_arbiter_if;
  logic        fpu_valid_i;
  logic        fpu_ready_o;
  logic [31:0] fpu_data_i;
  logic [4:0]  fpu_rd_i;
  logic        fpu_rd_is_fp_i;
  logic [31:0] fpu_hart_id_i;

  logic        mem_valid_i;
  logic        mem_ready_o;
  logic [31:0] mem_data_i;
  logic [4:0]  mem_rd_i;

  logic        dir_valid_i;
  logic        dir_ready_o;
  logic [31:0] dir_data_i;
  logic [4:0]  dir_rd_i;
  logic [31:0] dir_hart_id_i;

  logic        fpr_we_o;
  logic [4:0]  fpr_waddr_o;
  logic [31:0] fpr_wdata_o;

  logic        c_p_valid_o;
  logic        c_p_ready_i;
  logic [31:0] c_p_data_o;
  logic [4:0]  c_p_rd_o;
  logic [31:0] c_p_hart_id_o;

  modport slave (
    input  fpu_valid_i, fpu_data_i, fpu_rd_i, fpu_rd_is_fp_i, fpu_hart_id_i,
    input  mem_valid_i, mem_data_i, mem_rd_i,
    input  dir_valid_i, dir_data_i, dir_rd_i, dir_hart_id_i,
    input  c_p_ready_i,
    output fpu_ready_o, mem_ready_o, dir_ready_o,
    output fpr_we_o, fpr_waddr_o, fpr_wdata_o,
    output c_p_valid_o, c_p_data_o, c_p_rd_o, c_p_hart_id_o
  );

  modport master (
    output fpu_valid_i, fpu_data_i, fpu_rd_i, fpu_rd_is_fp_i, fpu_hart_id_i,
    output mem_valid_i, mem_data_i, mem_rd_i,
    output dir_valid_i, dir_data_i, dir_rd_i, dir_hart_id_i,
    output c_p_ready_i,
    input  fpu_ready_o, mem_ready_o, dir_ready_o,
    input  fpr_we_o, fpr_waddr_o, fpr_wdata_o,
    input  c_p_valid_o, c_p_data_o, c_p_rd_o, c_p_hart_id_o
  );
endinterface

// File: rtl/fpu_ss_wb_arbiter.sv
// Arbitrates fpnew, load and direct results onto the FP regfile write port (combinational)
// and the registered C-response channel, with fixed priority plus starvation aging per port.
module fpu_ss_wb_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic                 clk_i,
  input logic                 rst_i,
  fpu_ss_wb_arbiter_if.slave  bus
);

  localparam logic [3:0] AgeLimit = 4'(STARVE_LIMIT);
  localparam bit         AgingEn  = (STARVE_LIMIT != 0);

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_FPU,
    SRC_DIR
  } int_src_e;

  logic [3:0]  fp_age_q, fp_age_d;
  logic [3:0]  int_age_q, int_age_d;
  logic        c_p_valid_q, c_p_valid_d;
  logic [31:0] c_p_data_q, c_p_data_d;
  logic [4:0]  c_p_rd_q, c_p_rd_d;
  logic [31:0] c_p_hart_q, c_p_hart_d;

  logic     fpu_fp_req, fpu_int_req, mem_req, dir_req;
  logic     fp_flip, int_flip, can_load;
  logic     gnt_mem, gnt_fpu_fp, gnt_fpu_int, gnt_dir;
  int_src_e int_src;

  assign fpu_fp_req  = bus.fpu_valid_i & bus.fpu_rd_is_fp_i;
  assign fpu_int_req = bus.fpu_valid_i & ~bus.fpu_rd_is_fp_i;
  assign mem_req     = bus.mem_valid_i;
  assign dir_req     = bus.dir_valid_i;

  // A saturated counter inverts priority until the starved source is served.
  assign fp_flip  = AgingEn && (fp_age_q == AgeLimit);
  assign int_flip = AgingEn && (int_age_q == AgeLimit);

  assign gnt_mem    = ~rst_i & mem_req & ~(fpu_fp_req & fp_flip);
  assign gnt_fpu_fp = ~rst_i & fpu_fp_req & (~mem_req | fp_flip);

  // The output register refills in the same cycle it drains, giving full throughput.
  assign can_load    = ~c_p_valid_q | bus.c_p_ready_i;
  assign gnt_fpu_int = ~rst_i & can_load & fpu_int_req & (~dir_req | ~int_flip);
  assign gnt_dir     = ~rst_i & can_load & dir_req & (~fpu_int_req | int_flip);

  assign int_src = gnt_fpu_int ? SRC_FPU : (gnt_dir ? SRC_DIR : SRC_NONE);

  assign bus.fpu_ready_o = gnt_fpu_fp | gnt_fpu_int;
  assign bus.mem_ready_o = gnt_mem;
  assign bus.dir_ready_o = gnt_dir;

  // NOTE: every output of a combinational block gets a default first so no path infers a latch.
  always_comb begin
    bus.fpr_we_o    = gnt_mem | gnt_fpu_fp;
    bus.fpr_waddr_o = '0;
    bus.fpr_wdata_o = '0;
    if (gnt_mem) begin
      bus.fpr_waddr_o = bus.mem_rd_i;
      bus.fpr_wdata_o = bus.mem_data_i;
    end else if (gnt_fpu_fp) begin
      bus.fpr_waddr_o = bus.fpu_rd_i;
      bus.fpr_wdata_o = bus.fpu_data_i;
    end
  end

  always_comb begin
    fp_age_d = fp_age_q;
    if (gnt_fpu_fp) begin
      fp_age_d = '0;
    end else if (fpu_fp_req && (fp_age_q < AgeLimit)) begin
      fp_age_d = fp_age_q + 4'd1;
    end
  end

  // dir only ages in cycles where the register could actually have taken it.
  always_comb begin
    int_age_d = int_age_q;
    if (gnt_dir) begin
      int_age_d = '0;
    end else if (dir_req && can_load && (int_age_q < AgeLimit)) begin
      int_age_d = int_age_q + 4'd1;
    end
  end

  always_comb begin
    c_p_valid_d = c_p_valid_q;
    c_p_data_d  = c_p_data_q;
    c_p_rd_d    = c_p_rd_q;
    c_p_hart_d  = c_p_hart_q;
    unique case (int_src)
      SRC_FPU: begin
        c_p_valid_d = 1'b1;
        c_p_data_d  = bus.fpu_data_i;
        c_p_rd_d    = bus.fpu_rd_i;
        c_p_hart_d  = bus.fpu_hart_id_i;
      end
      SRC_DIR: begin
        c_p_valid_d = 1'b1;
        c_p_data_d  = bus.dir_data_i;
        c_p_rd_d    = bus.dir_rd_i;
        c_p_hart_d  = bus.dir_hart_id_i;
      end
      default: begin
        if (c_p_valid_q && bus.c_p_ready_i) begin
          c_p_valid_d = 1'b0;
          c_p_data_d  = '0;
          c_p_rd_d    = '0;
          c_p_hart_d  = '0;
        end
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fp_age_q    <= '0;
      int_age_q   <= '0;
      c_p_valid_q <= 1'b0;
      c_p_data_q  <= '0;
      c_p_rd_q    <= '0;
      c_p_hart_q  <= '0;
    end else begin
      fp_age_q    <= fp_age_d;
      int_age_q   <= int_age_d;
      c_p_valid_q <= c_p_valid_d;
      c_p_data_q  <= c_p_data_d;
      c_p_rd_q    <= c_p_rd_d;
      c_p_hart_q  <= c_p_hart_d;
    end
  end

  assign bus.c_p_valid_o   = c_p_valid_q;
  assign bus.c_p_data_o    = c_p_data_q;
  assign bus.c_p_rd_o      = c_p_rd_q;
  assign bus.c_p_hart_id_o = c_p_hart_q;

endmodule

// File: tb/tb_fpu_ss_wb_arbiter.sv
// Directed bench for fpu_ss_wb_arbiter: a vector table for the combinational FP port plus
// hand-written sequences for aging, backpressure, parallel grants and reset.
module tb_fpu_ss_wb_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  int   hs_cnt = 0;

  always #5 clk = ~clk;

  fpu_ss_wb_arbiter_if bus ();

  fpu_ss_wb_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always @(posedge clk) begin
    if (bus.c_p_valid_o === 1'b1 && bus.c_p_ready_i === 1'b1) hs_cnt <= hs_cnt + 1;
  end

  typedef struct {
    logic        mem_v;
    logic [4:0]  mem_rd;
    logic [31:0] mem_data;
    logic        fpu_v;
    logic        fpu_fp;
    logic [4:0]  fpu_rd;
    logic [31:0] fpu_data;
    logic        dir_v;
    logic        exp_we;
    logic [4:0]  exp_waddr;
    logic [31:0] exp_wdata;
    logic        exp_mem_rdy;
    logic        exp_fpu_rdy;
    logic        exp_dir_rdy;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.fpu_valid_i    = 1'b0;
    bus.fpu_data_i     = '0;
    bus.fpu_rd_i       = '0;
    bus.fpu_rd_is_fp_i = 1'b0;
    bus.fpu_hart_id_i  = '0;
    bus.mem_valid_i    = 1'b0;
    bus.mem_data_i     = '0;
    bus.mem_rd_i       = '0;
    bus.dir_valid_i    = 1'b0;
    bus.dir_data_i     = '0;
    bus.dir_rd_i       = '0;
    bus.dir_hart_id_i  = '0;
    bus.c_p_ready_i    = 1'b1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      drive_idle();
    end
  endtask

  task automatic fp_aging_seq(input string tag);
    for (int c = 0; c < 6; c++) begin
      tick();
      drive_idle();
      bus.mem_valid_i    = 1'b1;
      bus.mem_rd_i       = 5'd1;
      bus.mem_data_i     = 32'h3F80_0000;
      bus.fpu_valid_i    = 1'b1;
      bus.fpu_rd_is_fp_i = 1'b1;
      bus.fpu_rd_i       = 5'd7;
      bus.fpu_data_i     = 32'h40E0_0000;
      #4;
      check($sformatf("%s c%0d fpu_ready", tag, c), 32'(bus.fpu_ready_o), 32'(c == 4));
      check($sformatf("%s c%0d mem_ready", tag, c), 32'(bus.mem_ready_o), 32'(c != 4));
      check($sformatf("%s c%0d waddr", tag, c), 32'(bus.fpr_waddr_o), (c == 4) ? 32'd7 : 32'd1);
    end
    idle_cycles(1);
  endtask

  task automatic int_aging_seq(input string tag);
    for (int c = 0; c < 6; c++) begin
      tick();
      drive_idle();
      if (c < 5) begin
        bus.fpu_valid_i    = 1'b1;
        bus.fpu_rd_is_fp_i = 1'b0;
        bus.fpu_rd_i       = 5'd5;
        bus.fpu_data_i     = 32'h0000_F00D;
        bus.fpu_hart_id_i  = 32'h33;
        bus.dir_valid_i    = 1'b1;
        bus.dir_rd_i       = 5'd20;
        bus.dir_data_i     = 32'h0000_D1D0;
        bus.dir_hart_id_i  = 32'h44;
      end
      #4;
      if (c < 5) begin
        check($sformatf("%s c%0d fpu_ready", tag, c), 32'(bus.fpu_ready_o), 32'(c < 4));
        check($sformatf("%s c%0d dir_ready", tag, c), 32'(bus.dir_ready_o), 32'(c == 4));
      end
      if (c >= 1) begin
        check($sformatf("%s c%0d c_p_valid", tag, c), 32'(bus.c_p_valid_o), 32'd1);
        check($sformatf("%s c%0d c_p_rd", tag, c), 32'(bus.c_p_rd_o), (c == 5) ? 32'd20 : 32'd5);
        check($sformatf("%s c%0d c_p_hart", tag, c), bus.c_p_hart_id_o,
              (c == 5) ? 32'h44 : 32'h33);
      end
    end
    idle_cycles(1);
  endtask

  initial begin
    int hs_snap;

    //              mem_v rd  data            fpu_v fp rd  data           dir we addr wdata          mr fr dr
    vecs[0] = '{1'b0, 5'd0, 32'h0,         1'b0, 1'b0, 5'd0, 32'h0,         1'b0, 1'b0, 5'd0, 32'h0,         1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 5'd3, 32'h3F80_0000, 1'b0, 1'b0, 5'd0, 32'h0,         1'b0, 1'b1, 5'd3, 32'h3F80_0000, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 5'd0, 32'h0,         1'b1, 1'b1, 5'd7, 32'h4000_0000, 1'b0, 1'b1, 5'd7, 32'h4000_0000, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 5'd2, 32'h1111_1111, 1'b1, 1'b1, 5'd7, 32'h4000_0000, 1'b0, 1'b1, 5'd2, 32'h1111_1111, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 5'd0, 32'h0,         1'b1, 1'b1, 5'd9, 32'h4040_0000, 1'b0, 1'b1, 5'd9, 32'h4040_0000, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 5'd2, 32'h2222_2222, 1'b1, 1'b0, 5'd5, 32'hDEAD_BEEF, 1'b0, 1'b1, 5'd2, 32'h2222_2222, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 5'd0, 32'h0,         1'b1, 1'b0, 5'd5, 32'hDEAD_BEEF, 1'b1, 1'b0, 5'd0, 32'h0,         1'b0, 1'b1, 1'b0};
    vecs[7] = '{1'b0, 5'd0, 32'h0,         1'b0, 1'b0, 5'd0, 32'h0,         1'b1, 1'b0, 5'd0, 32'h0,         1'b0, 1'b0, 1'b1};
    vecs[8] = '{1'b0, 5'd0, 32'h0,         1'b1, 1'b1, 5'd4, 32'h3F00_0000, 1'b1, 1'b1, 5'd4, 32'h3F00_0000, 1'b0, 1'b1, 1'b1};

    // Reset held for two cycles with every source requesting.
    drive_idle();
    rst = 1'b1;
    bus.mem_valid_i    = 1'b1;
    bus.mem_rd_i       = 5'd3;
    bus.fpu_valid_i    = 1'b1;
    bus.fpu_rd_is_fp_i = 1'b0;
    bus.dir_valid_i    = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick();
      #4;
      check($sformatf("rst c%0d mem_ready", c), 32'(bus.mem_ready_o), 32'd0);
      check($sformatf("rst c%0d fpu_ready", c), 32'(bus.fpu_ready_o), 32'd0);
      check($sformatf("rst c%0d dir_ready", c), 32'(bus.dir_ready_o), 32'd0);
      check($sformatf("rst c%0d fpr_we", c), 32'(bus.fpr_we_o), 32'd0);
      check($sformatf("rst c%0d c_p_valid", c), 32'(bus.c_p_valid_o), 32'd0);
    end
    tick();
    rst = 1'b0;
    drive_idle();
    bus.mem_valid_i = 1'b1;
    bus.mem_rd_i    = 5'd3;
    bus.mem_data_i  = 32'h3F80_0000;
    #4;
    check("post_rst fpr_we", 32'(bus.fpr_we_o), 32'd1);
    check("post_rst waddr", 32'(bus.fpr_waddr_o), 32'd3);
    check("post_rst wdata", bus.fpr_wdata_o, 32'h3F80_0000);
    check("post_rst mem_ready", 32'(bus.mem_ready_o), 32'd1);

    // Combinational FP-port and grant vectors.
    for (int i = 0; i < 9; i++) begin
      tick();
      drive_idle();
      bus.mem_valid_i    = vecs[i].mem_v;
      bus.mem_rd_i       = vecs[i].mem_rd;
      bus.mem_data_i     = vecs[i].mem_data;
      bus.fpu_valid_i    = vecs[i].fpu_v;
      bus.fpu_rd_is_fp_i = vecs[i].fpu_fp;
      bus.fpu_rd_i       = vecs[i].fpu_rd;
      bus.fpu_data_i     = vecs[i].fpu_data;
      bus.dir_valid_i    = vecs[i].dir_v;
      bus.dir_rd_i       = 5'd12;
      bus.dir_data_i     = 32'h0000_0D1D;
      bus.dir_hart_id_i  = 32'h22;
      #4;
      check($sformatf("vec%0d fpr_we", i), 32'(bus.fpr_we_o), 32'(vecs[i].exp_we));
      check($sformatf("vec%0d waddr", i), 32'(bus.fpr_waddr_o), 32'(vecs[i].exp_waddr));
      check($sformatf("vec%0d wdata", i), bus.fpr_wdata_o, vecs[i].exp_wdata);
      check($sformatf("vec%0d mem_ready", i), 32'(bus.mem_ready_o), 32'(vecs[i].exp_mem_rdy));
      check($sformatf("vec%0d fpu_ready", i), 32'(bus.fpu_ready_o), 32'(vecs[i].exp_fpu_rdy));
      check($sformatf("vec%0d dir_ready", i), 32'(bus.dir_ready_o), 32'(vecs[i].exp_dir_rdy));
    end
    idle_cycles(2);

    fp_aging_seq("fp_age");

    // Integer latency, backpressure hold and streaming.
    tick();
    drive_idle();
    bus.c_p_ready_i   = 1'b0;
    bus.dir_valid_i   = 1'b1;
    bus.dir_rd_i      = 5'd10;
    bus.dir_data_i    = 32'h0000_0001;
    bus.dir_hart_id_i = 32'h11;
    #4;
    check("bp c0 dir_ready", 32'(bus.dir_ready_o), 32'd1);
    check("bp c0 c_p_valid", 32'(bus.c_p_valid_o), 32'd0);
    for (int c = 1; c <= 3; c++) begin
      tick();
      bus.c_p_ready_i = 1'b0;
      bus.dir_rd_i    = 5'd11;
      bus.dir_data_i  = 32'h0000_0002;
      #4;
      check($sformatf("bp c%0d c_p_valid", c), 32'(bus.c_p_valid_o), 32'd1);
      check($sformatf("bp c%0d c_p_data", c), bus.c_p_data_o, 32'h0000_0001);
      check($sformatf("bp c%0d c_p_rd", c), 32'(bus.c_p_rd_o), 32'd10);
      check($sformatf("bp c%0d c_p_hart", c), bus.c_p_hart_id_o, 32'h11);
      check($sformatf("bp c%0d dir_ready", c), 32'(bus.dir_ready_o), 32'd0);
    end
    tick();
    bus.c_p_ready_i = 1'b1;
    #4;
    check("bp c4 c_p_data", bus.c_p_data_o, 32'h0000_0001);
    check("bp c4 dir_ready", 32'(bus.dir_ready_o), 32'd1);
    tick();
    bus.dir_rd_i   = 5'd12;
    bus.dir_data_i = 32'h0000_0003;
    #4;
    check("bp c5 c_p_rd", 32'(bus.c_p_rd_o), 32'd11);
    check("bp c5 c_p_data", bus.c_p_data_o, 32'h0000_0002);
    check("bp c5 dir_ready", 32'(bus.dir_ready_o), 32'd1);
    tick();
    drive_idle();
    #4;
    check("bp c6 c_p_valid", 32'(bus.c_p_valid_o), 32'd1);
    check("bp c6 c_p_rd", 32'(bus.c_p_rd_o), 32'd12);
    check("bp c6 c_p_data", bus.c_p_data_o, 32'h0000_0003);
    tick();
    #4;
    check("bp c7 c_p_valid", 32'(bus.c_p_valid_o), 32'd0);
    check("bp c7 c_p_data", bus.c_p_data_o, 32'd0);
    check("bp c7 c_p_rd", 32'(bus.c_p_rd_o), 32'd0);
    check("bp c7 c_p_hart", bus.c_p_hart_id_o, 32'd0);

    int_aging_seq("int_age");

    // Parallel grants on both ports in one cycle.
    tick();
    drive_idle();
    bus.mem_valid_i    = 1'b1;
    bus.mem_rd_i       = 5'd2;
    bus.mem_data_i     = 32'h4049_0FDB;
    bus.fpu_valid_i    = 1'b1;
    bus.fpu_rd_is_fp_i = 1'b0;
    bus.fpu_rd_i       = 5'd5;
    bus.fpu_data_i     = 32'hDEAD_BEEF;
    bus.fpu_hart_id_i  = 32'h55;
    #4;
    check("par mem_ready", 32'(bus.mem_ready_o), 32'd1);
    check("par fpu_ready", 32'(bus.fpu_ready_o), 32'd1);
    check("par waddr", 32'(bus.fpr_waddr_o), 32'd2);
    tick();
    drive_idle();
    #4;
    check("par c_p_valid", 32'(bus.c_p_valid_o), 32'd1);
    check("par c_p_data", bus.c_p_data_o, 32'hDEAD_BEEF);
    check("par c_p_rd", 32'(bus.c_p_rd_o), 32'd5);
    idle_cycles(1);

    // Reset mid-operation: aged counters and a stalled entry are discarded.
    tick();
    drive_idle();
    bus.fpu_valid_i    = 1'b1;
    bus.fpu_rd_is_fp_i = 1'b0;
    bus.fpu_rd_i       = 5'd6;
    bus.fpu_data_i     = 32'h0000_0006;
    bus.fpu_hart_id_i  = 32'h66;
    bus.dir_valid_i    = 1'b1;
    bus.dir_rd_i       = 5'd21;
    #4;
    check("mid p fpu_ready", 32'(bus.fpu_ready_o), 32'd1);
    for (int c = 0; c < 2; c++) begin
      tick();
      drive_idle();
      bus.c_p_ready_i    = 1'b0;
      bus.mem_valid_i    = 1'b1;
      bus.mem_rd_i       = 5'd1;
      bus.fpu_valid_i    = 1'b1;
      bus.fpu_rd_is_fp_i = 1'b1;
      bus.fpu_rd_i       = 5'd7;
      #4;
      check($sformatf("mid c%0d c_p_valid", c), 32'(bus.c_p_valid_o), 32'd1);
      check($sformatf("mid c%0d c_p_rd", c), 32'(bus.c_p_rd_o), 32'd6);
      check($sformatf("mid c%0d mem_ready", c), 32'(bus.mem_ready_o), 32'd1);
    end
    hs_snap = hs_cnt;
    tick();
    rst = 1'b1;
    #4;
    check("mid rst mem_ready", 32'(bus.mem_ready_o), 32'd0);
    check("mid rst fpu_ready", 32'(bus.fpu_ready_o), 32'd0);
    check("mid rst fpr_we", 32'(bus.fpr_we_o), 32'd0);
    tick();
    rst = 1'b0;
    drive_idle();
    bus.c_p_ready_i = 1'b0;
    #4;
    check("mid post c_p_valid", 32'(bus.c_p_valid_o), 32'd0);
    check("mid post c_p_data", bus.c_p_data_o, 32'd0);
    check("mid post c_p_rd", 32'(bus.c_p_rd_o), 32'd0);
    check("mid post c_p_hart", bus.c_p_hart_id_o, 32'd0);
    check("mid post handshakes", 32'(hs_cnt), 32'(hs_snap));
    fp_aging_seq("mid fp_age");
    int_aging_seq("mid int_age");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fpu_ss_wb_arbiter.md
Name: fpu_ss_wb_arbiter

Overview:
Shares the FPU subsystem's two writeback resources between three result sources. The resources are the single FP register-file write port and the C-response channel back to the core. The sources are the fpnew result stream, the memory load response stream and the direct-result stream (CSR reads and integer moves/compares that bypass fpnew). The block sits between those producers and the regfile/core and replaces ad-hoc writeback muxing. Fixed priority applies, with starvation aging on each resource.

Parameters:
STARVE_LIMIT, 4, consecutive lost arbitration cycles before the low-priority source is promoted; 0 disables aging (pure fixed priority); legal range 0..15.

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
fpu_valid_i  in  1  fpnew result valid
fpu_ready_o  out  1  fpnew result accepted
fpu_data_i  in  32  fpnew result
fpu_rd_i  in  5  destination register
fpu_rd_is_fp_i  in  1  1 = FP regfile destination, 0 = integer (C-response)
fpu_hart_id_i  in  32  hart id tag
mem_valid_i  in  1  load data valid (always FP destination)
mem_ready_o  out  1  load data accepted
mem_data_i  in  32  load data
mem_rd_i  in  5  load destination FP register
dir_valid_i  in  1  direct integer result valid (CSR read / move)
dir_ready_o  out  1  direct result accepted
dir_data_i  in  32  direct result
dir_rd_i  in  5  destination integer register
dir_hart_id_i  in  32  hart id
fpr_we_o  out  1  FP regfile write enable
fpr_waddr_o  out  5  FP regfile write address
fpr_wdata_o  out  32  FP regfile write data
c_p_valid_o  out  1  C-response valid
c_p_ready_i  in  1  C-response ready from core
c_p_data_o  out  32  C-response data
c_p_rd_o  out  5  C-response destination register
c_p_hart_id_o  out  32  C-response hart id

Behaviour:
- Handshakes are valid/ready. A transfer occurs on valid & ready. A source must hold valid and payload stable until accepted. Ready outputs may depend combinationally on the same source's valid and rd_is_fp.
- FP port (combinational, 0-cycle latency):
  - Candidates: mem, and fpu when fpu_rd_is_fp_i = 1.
  - Default priority: mem > fpu.
  - fpr_we_o = 1 when any candidate is valid. Address and data come from the winner.
  - The winner's ready is 1; the loser's ready is 0.
  - When fpr_we_o = 0, fpr_waddr_o and fpr_wdata_o are 0.
- FP aging counter fp_age (4 bits):
  - Increments each cycle the fpu FP candidate is valid but not granted, saturating at STARVE_LIMIT.
  - Clears on an fpu FP grant.
  - When fp_age == STARVE_LIMIT and STARVE_LIMIT != 0, priority flips to fpu > mem until the fpu grant.
- Integer port (registered, 1-cycle latency, one-entry output register):
  - Candidates: fpu when fpu_rd_is_fp_i = 0, and dir.
  - Default priority: fpu > dir, because the fpnew pipeline backs up while dir only stalls issue.
  - The register can load when c_p_valid_o = 0, or when c_p_valid_o & c_p_ready_i (same-cycle drain and refill, full throughput).
  - When it cannot load, both integer candidates see ready = 0.
  - On a load, the next cycle shows c_p_valid_o = 1 with the winner's data, rd and hart_id.
  - While c_p_valid_o & ~c_p_ready_i, all c_p_* outputs hold stable.
  - On a drain with no new load, c_p_valid_o goes to 0 and c_p_data_o/rd/hart_id go to 0.
- Integer aging counter int_age: mirrors fp_age for dir. It increments only in cycles where the register could load and dir lost. On saturation, priority flips to dir > fpu until the dir grant.
- The fpu source is steered by fpu_rd_is_fp_i: it competes on exactly one port per cycle. fpu_ready_o is the grant on that port.
- FP and integer arbitration are independent. mem→FP and fpu→integer can both be granted in the same cycle. dir→integer and fpu→FP can both be granted in the same cycle.
- Register hazards and ordering are the issue controller's responsibility. This block performs no rd comparison.
- Reset (rst_i = 1 at a clock edge): the output register empties, fp_age and int_age become 0, and c_p_valid_o/data/rd/hart_id become 0 on the next cycle.
  - Reset asserted while c_p_valid_o & ~c_p_ready_i drops the held entry without a handshake.
  - All ready outputs and fpr_we_o are 0 while rst_i = 1.

Test Plan:
- Reset: hold rst_i 2 cycles with all sources valid -> all readies 0, fpr_we_o 0, c_p_valid_o 0; at first post-reset edge with mem valid (rd 3, data 0x3F800000) -> fpr_we_o 1, fpr_waddr_o 3, mem_ready_o 1 same cycle.
- FP contention and aging (STARVE_LIMIT 4): mem and fpu-FP (rd 7) valid continuously -> mem granted cycles 0-3, fpu granted cycle 4 with fpr_waddr_o 7, mem again from cycle 5.
- Integer path latency/backpressure: dir valid (rd 10, data 0x0000_0001), c_p_ready_i 0 for 3 cycles -> c_p_valid_o 1 from next cycle, outputs stable 3 cycles; dir_ready_o 0 for a second dir beat until drain; with c_p_ready_i 1, back-to-back beats stream at 1 per cycle.
- Integer aging: fpu-int and dir both valid, c_p_ready_i 1 -> fpu wins 4 loads, dir wins the 5th (c_p_rd_o = dir_rd_i, hart_id = dir_hart_id_i).
- Parallel grants: mem (FP rd 2) and fpu-int (rd 5, data 0xDEAD_BEEF) same cycle -> mem_ready_o 1 and fpu_ready_o 1; fpr_waddr_o 2 that cycle; c_p_data_o 0xDEAD_BEEF next cycle.
- Reset mid-operation: c_p_valid_o 1 stalled, assert rst_i -> c_p_valid_o 0 next cycle, counters 0, no handshake counted.
